// File: rtl/sync_vg_pkg.sv
// rtl/sync_vg_pkg.sv - shared timing constants and types for the sync/video-timing generator
package sync_vg_pkg;

    typedef struct packed {
        int h_total;
        int h_sync;
        int h_bp;
        int h_act;
        int v_total;
        int v_sync;
        int v_bp;
        int v_act;
    } vg_timing_t;

    localparam vg_timing_t VG_720P60 = '{
        h_total: 1650, h_sync: 40, h_bp: 220, h_act: 1280,
        v_total: 750,  v_sync: 5,  v_bp: 20,  v_act: 720
    };

    localparam vg_timing_t VG_1080P60 = '{
        h_total: 2200, h_sync: 44, h_bp: 148, h_act: 1920,
        v_total: 1125, v_sync: 5,  v_bp: 36,  v_act: 1080
    };

    localparam vg_timing_t VG_480P60 = '{
        h_total: 800, h_sync: 96, h_bp: 48, h_act: 640,
        v_total: 525, v_sync: 2,  v_bp: 33, v_act: 480
    };

    typedef enum logic {
        CFG_IDLE = 1'b0,
        CFG_PEND = 1'b1
    } cfg_state_e;

endpackage

// File: rtl/sync_vg_axis.sv
// rtl/sync_vg_axis.sv - one timing axis: wrapping counter plus sync/active-window decode
module sync_vg_axis #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] total_i,
    input  logic [W-1:0] sync_i,
    input  logic [W-1:0] bp_i,
    input  logic [W-1:0] act_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o,
    output logic         sync_o,
    output logic         act_o,
    output logic [W-1:0] pos_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W:0]   act_start;
    logic [W:0]   act_stop;
    logic         past_start;

    // Window bounds carry one extra bit so sync+bp+act never wraps.
    assign act_start  = {1'b0, sync_i} + {1'b0, bp_i};
    assign act_stop   = act_start + {1'b0, act_i};
    assign past_start = {1'b0, cnt_q} >= act_start;

    assign cnt_o  = cnt_q;
    assign wrap_o = (cnt_q == total_i - W'(1));
    assign sync_o = (cnt_q < sync_i);
    assign act_o  = past_start && ({1'b0, cnt_q} < act_stop);
    assign pos_o  = past_start ? (cnt_q - act_start[W-1:0]) : '0;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sync_vg_prog.sv
// rtl/sync_vg_prog.sv - programmable video timing generator with frame-aligned config swap
module sync_vg_prog
    import sync_vg_pkg::*;
#(
    parameter int   X_BITS  = 12,
    parameter int   Y_BITS  = 12,
    parameter logic HS_POL  = 1'b1,
    parameter logic VS_POL  = 1'b1,
    parameter int   H_TOTAL = VG_720P60.h_total,
    parameter int   H_SYNC  = VG_720P60.h_sync,
    parameter int   H_BP    = VG_720P60.h_bp,
    parameter int   H_ACT   = VG_720P60.h_act,
    parameter int   V_TOTAL = VG_720P60.v_total,
    parameter int   V_SYNC  = VG_720P60.v_sync,
    parameter int   V_BP    = VG_720P60.v_bp,
    parameter int   V_ACT   = VG_720P60.v_act
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [X_BITS-1:0] cfg_h_total,
    input  logic [X_BITS-1:0] cfg_h_sync,
    input  logic [X_BITS-1:0] cfg_h_bp,
    input  logic [X_BITS-1:0] cfg_h_act,
    input  logic [Y_BITS-1:0] cfg_v_total,
    input  logic [Y_BITS-1:0] cfg_v_sync,
    input  logic [Y_BITS-1:0] cfg_v_bp,
    input  logic [Y_BITS-1:0] cfg_v_act,
    output logic              cfg_err,
    output logic              hs_out,
    output logic              vs_out,
    output logic              de_out,
    output logic              frame_start,
    output logic              line_start,
    output logic [X_BITS-1:0] x_act,
    output logic [Y_BITS-1:0] y_act
);

    localparam int HW = 4 * X_BITS;
    localparam int VW = 4 * Y_BITS;

    // Timing sets are packed {total, sync, bp, act}, total in the top slice.
    localparam logic [HW-1:0] H_DEF = {X_BITS'(H_TOTAL), X_BITS'(H_SYNC), X_BITS'(H_BP), X_BITS'(H_ACT)};
    localparam logic [VW-1:0] V_DEF = {Y_BITS'(V_TOTAL), Y_BITS'(V_SYNC), Y_BITS'(V_BP), Y_BITS'(V_ACT)};

    cfg_state_e        st_q, st_d;
    logic [HW-1:0]     hcfg_q, hcfg_d, hpend_q, hpend_d;
    logic [VW-1:0]     vcfg_q, vcfg_d, vpend_q, vpend_d;
    logic              err_q, err_d;
    logic              hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic              fs_q, fs_d, ls_q, ls_d;
    logic [X_BITS-1:0] x_q, x_d;
    logic [Y_BITS-1:0] y_q, y_d;

    logic [HW-1:0]     h_offer;
    logic [VW-1:0]     v_offer;
    logic [X_BITS:0]   h_need;
    logic [Y_BITS:0]   v_need;
    logic              cfg_ok;
    logic              swap_ok;

    logic [X_BITS-1:0] h_cnt, h_pos;
    logic [Y_BITS-1:0] v_cnt, v_pos;
    logic              h_wrap, h_in_sync, h_in_act;
    logic              v_wrap, v_in_sync, v_in_act;

    assign h_offer = {cfg_h_total, cfg_h_sync, cfg_h_bp, cfg_h_act};
    assign v_offer = {cfg_v_total, cfg_v_sync, cfg_v_bp, cfg_v_act};
    assign h_need  = {1'b0, cfg_h_sync} + {1'b0, cfg_h_bp} + {1'b0, cfg_h_act};
    assign v_need  = {1'b0, cfg_v_sync} + {1'b0, cfg_v_bp} + {1'b0, cfg_v_act};

    assign cfg_ok = (cfg_h_total != '0) && (cfg_h_sync != '0) && (cfg_h_bp != '0) && (cfg_h_act != '0)
                 && (cfg_v_total != '0) && (cfg_v_sync != '0) && (cfg_v_bp != '0) && (cfg_v_act != '0)
                 && (h_need <= {1'b0, cfg_h_total}) && (v_need <= {1'b0, cfg_v_total});

    // Swap only on the last pixel of a frame, or at once when stopped (counters are parked at 0).
    assign swap_ok = ~en | (h_wrap & v_wrap);

    sync_vg_axis #(.W(X_BITS)) u_h_axis (
        .clk     (clk),
        .rstn    (rstn),
        .clr_i   (~en),
        .inc_i   (en),
        .total_i (hcfg_q[HW-1 -: X_BITS]),
        .sync_i  (hcfg_q[3*X_BITS-1 -: X_BITS]),
        .bp_i    (hcfg_q[2*X_BITS-1 -: X_BITS]),
        .act_i   (hcfg_q[X_BITS-1:0]),
        .cnt_o   (h_cnt),
        .wrap_o  (h_wrap),
        .sync_o  (h_in_sync),
        .act_o   (h_in_act),
        .pos_o   (h_pos)
    );

    sync_vg_axis #(.W(Y_BITS)) u_v_axis (
        .clk     (clk),
        .rstn    (rstn),
        .clr_i   (~en),
        .inc_i   (en & h_wrap),
        .total_i (vcfg_q[VW-1 -: Y_BITS]),
        .sync_i  (vcfg_q[3*Y_BITS-1 -: Y_BITS]),
        .bp_i    (vcfg_q[2*Y_BITS-1 -: Y_BITS]),
        .act_i   (vcfg_q[Y_BITS-1:0]),
        .cnt_o   (v_cnt),
        .wrap_o  (v_wrap),
        .sync_o  (v_in_sync),
        .act_o   (v_in_act),
        .pos_o   (v_pos)
    );

    always_comb begin
        st_d    = st_q;
        hcfg_d  = hcfg_q;
        vcfg_d  = vcfg_q;
        hpend_d = hpend_q;
        vpend_d = vpend_q;
        err_d   = 1'b0;
        case (st_q)
            CFG_IDLE: begin
                if (cfg_valid) begin
                    if (cfg_ok) begin
                        hpend_d = h_offer;
                        vpend_d = v_offer;
                        st_d    = CFG_PEND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CFG_PEND: begin
                if (swap_ok) begin
                    hcfg_d = hpend_q;
                    vcfg_d = vpend_q;
                    st_d   = CFG_IDLE;
                end
            end
            default: st_d = CFG_IDLE;
        endcase
    end

    always_comb begin
        hs_d = ~HS_POL;
        vs_d = ~VS_POL;
        de_d = 1'b0;
        fs_d = 1'b0;
        ls_d = 1'b0;
        x_d  = '0;
        y_d  = '0;
        if (en) begin
            hs_d = h_in_sync ? HS_POL : ~HS_POL;
            vs_d = v_in_sync ? VS_POL : ~VS_POL;
            de_d = h_in_act & v_in_act;
            ls_d = (h_cnt == '0);
            fs_d = (h_cnt == '0) && (v_cnt == '0);
            x_d  = h_pos;
            y_d  = v_pos;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            st_q    <= CFG_IDLE;
            hcfg_q  <= H_DEF;
            vcfg_q  <= V_DEF;
            hpend_q <= '0;
            vpend_q <= '0;
            err_q   <= 1'b0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            st_q    <= st_d;
            hcfg_q  <= hcfg_d;
            vcfg_q  <= vcfg_d;
            hpend_q <= hpend_d;
            vpend_q <= vpend_d;
            err_q   <= err_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            fs_q    <= fs_d;
            ls_q    <= ls_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign cfg_ready   = (st_q == CFG_IDLE);
    assign cfg_err     = err_q;
    assign hs_out      = hs_q;
    assign vs_out      = vs_q;
    assign de_out      = de_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;
    assign x_act       = x_q;
    assign y_act       = y_q;

endmodule

// File: tb/tb_sync_vg_prog.sv
// tb/tb_sync_vg_prog.sv - self-checking bench for sync_vg_prog
module tb_sync_vg_prog;

    typedef struct {
        int ht, hs, hb, ha, vt, vs, vb, va;
    } tim_t;

    typedef struct packed {
        logic        ready;
        logic        err;
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic        ls;
        logic [11:0] x;
        logic [11:0] y;
    } obs_t;

    typedef struct {
        tim_t t;
        bit   en_v;
        bit   exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rstn, en, cfg_valid;
    logic [11:0] cfg_h_total, cfg_h_sync, cfg_h_bp, cfg_h_act;
    logic [11:0] cfg_v_total, cfg_v_sync, cfg_v_bp, cfg_v_act;

    logic cfg_ready, cfg_err, hs_out, vs_out, de_out, frame_start, line_start;
    logic [11:0] x_act, y_act;
    logic cfg_ready_n, cfg_err_n, hs_out_n, vs_out_n, de_out_n, frame_start_n, line_start_n;
    logic [11:0] x_act_n, y_act_n;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sync_vg_prog dut (
        .clk(clk), .rstn(rstn), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_h_total(cfg_h_total), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp), .cfg_h_act(cfg_h_act),
        .cfg_v_total(cfg_v_total), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp), .cfg_v_act(cfg_v_act),
        .cfg_err(cfg_err), .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out),
        .frame_start(frame_start), .line_start(line_start), .x_act(x_act), .y_act(y_act)
    );

    sync_vg_prog #(.HS_POL(1'b0), .VS_POL(1'b0)) dut_n (
        .clk(clk), .rstn(rstn), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_n),
        .cfg_h_total(cfg_h_total), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp), .cfg_h_act(cfg_h_act),
        .cfg_v_total(cfg_v_total), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp), .cfg_v_act(cfg_v_act),
        .cfg_err(cfg_err_n), .hs_out(hs_out_n), .vs_out(vs_out_n), .de_out(de_out_n),
        .frame_start(frame_start_n), .line_start(line_start_n), .x_act(x_act_n), .y_act(y_act_n)
    );

    localparam tim_t DEF = '{ht: 1650, hs: 40, hb: 220, ha: 1280, vt: 750, vs: 5, vb: 20, va: 720};

    function automatic bit fits(tim_t t);
        return t.ht != 0 && t.hs != 0 && t.hb != 0 && t.ha != 0 &&
               t.vt != 0 && t.vs != 0 && t.vb != 0 && t.va != 0 &&
               (t.hs + t.hb + t.ha) <= t.ht && (t.vs + t.vb + t.va) <= t.vt;
    endfunction

    // Reference model: expected registered outputs are queued at each edge.
    obs_t exp_q[$];
    int   mh, mv;
    tim_t mcfg, mpend, moff;
    bit   mpv, mapply;
    obs_t me;

    always @(posedge clk) begin
        moff = '{ht: int'(cfg_h_total), hs: int'(cfg_h_sync), hb: int'(cfg_h_bp), ha: int'(cfg_h_act),
                 vt: int'(cfg_v_total), vs: int'(cfg_v_sync), vb: int'(cfg_v_bp), va: int'(cfg_v_act)};
        me = '0;
        if (!rstn) begin
            mh = 0; mv = 0; mcfg = DEF; mpv = 0;
            me.ready = 1'b1;
        end else begin
            if (en) begin
                me.hs = (mh < mcfg.hs);
                me.vs = (mv < mcfg.vs);
                me.de = (mh >= mcfg.hs + mcfg.hb) && (mh < mcfg.hs + mcfg.hb + mcfg.ha) &&
                        (mv >= mcfg.vs + mcfg.vb) && (mv < mcfg.vs + mcfg.vb + mcfg.va);
                me.x  = (mh >= mcfg.hs + mcfg.hb) ? 12'(mh - mcfg.hs - mcfg.hb) : 12'd0;
                me.y  = (mv >= mcfg.vs + mcfg.vb) ? 12'(mv - mcfg.vs - mcfg.vb) : 12'd0;
                me.ls = (mh == 0);
                me.fs = (mh == 0) && (mv == 0);
            end
            me.err = cfg_valid && !mpv && !fits(moff);
            mapply = mpv && (!en || (mh == mcfg.ht - 1 && mv == mcfg.vt - 1));
            if (!en) begin
                mh = 0; mv = 0;
            end else if (mh == mcfg.ht - 1) begin
                mh = 0;
                mv = (mv == mcfg.vt - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            if (mapply) begin
                mcfg = mpend; mpv = 0;
            end else if (cfg_valid && !mpv && fits(moff)) begin
                mpend = moff; mpv = 1;
            end
            me.ready = !mpv;
        end
        exp_q.push_back(me);
    end

    obs_t se, sg, sgn;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            se = exp_q.pop_front();
            sg = '{ready: cfg_ready, err: cfg_err, hs: hs_out, vs: vs_out, de: de_out,
                   fs: frame_start, ls: line_start, x: x_act, y: y_act};
            sgn = '{ready: cfg_ready_n, err: cfg_err_n, hs: hs_out_n, vs: vs_out_n, de: de_out_n,
                    fs: frame_start_n, ls: line_start_n, x: x_act_n, y: y_act_n};
            n_cmp++;
            if (sg !== se) begin
                n_bad++;
                $display("FAIL sb_pol1 t=%0t actual=%h required=%h", $time, sg, se);
            end
            se.hs = ~se.hs;
            se.vs = ~se.vs;
            n_cmp++;
            if (sgn !== se) begin
                n_bad++;
                $display("FAIL sb_pol0 t=%0t actual=%h required=%h", $time, sgn, se);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", name, got, exp);
        end
    endtask

    task automatic drive_cfg(input tim_t t);
        cfg_h_total = 12'(t.ht); cfg_h_sync = 12'(t.hs); cfg_h_bp = 12'(t.hb); cfg_h_act = 12'(t.ha);
        cfg_v_total = 12'(t.vt); cfg_v_sync = 12'(t.vs); cfg_v_bp = 12'(t.vb); cfg_v_act = 12'(t.va);
    endtask

    task automatic offer_once(input tim_t t);
        int n = 0;
        drive_cfg(t);
        cfg_valid = 1'b1;
        while (!cfg_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        check("offer_taken", int'(n < 400), 1);
    endtask

    task automatic wait_fs(input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < bound);
    endtask

    vec_t vecs[6];
    int   n, hsc, lc, pos, li, dec, xsum, mask, bad, st, errs, vsl;
    tim_t ta, tb_, tc, td;

    initial begin
        vecs[0] = '{t: '{ht: 10, hs: 2, hb: 2, ha: 7, vt: 6, vs: 1, vb: 1, va: 3}, en_v: 1'b1, exp_err: 1'b1};
        vecs[1] = '{t: '{ht: 1650, hs: 0, hb: 220, ha: 1280, vt: 750, vs: 5, vb: 20, va: 720}, en_v: 1'b1, exp_err: 1'b1};
        vecs[2] = '{t: '{ht: 20, hs: 3, hb: 3, ha: 10, vt: 6, vs: 2, vb: 2, va: 3}, en_v: 1'b1, exp_err: 1'b1};
        vecs[3] = '{t: '{ht: 20, hs: 3, hb: 3, ha: 10, vt: 8, vs: 1, vb: 1, va: 4}, en_v: 1'b0, exp_err: 1'b0};
        vecs[4] = '{t: '{ht: 20, hs: 3, hb: 3, ha: 10, vt: 8, vs: 1, vb: 1, va: 0}, en_v: 1'b0, exp_err: 1'b1};
        vecs[5] = '{t: '{ht: 16, hs: 3, hb: 3, ha: 10, vt: 6, vs: 1, vb: 1, va: 4}, en_v: 1'b0, exp_err: 1'b0};
        ta  = '{ht: 10, hs: 2, hb: 2, ha: 4, vt: 6, vs: 1, vb: 1, va: 3};
        tb_ = '{ht: 12, hs: 2, hb: 2, ha: 6, vt: 6, vs: 1, vb: 1, va: 3};
        tc  = '{ht: 14, hs: 2, hb: 2, ha: 8, vt: 6, vs: 1, vb: 1, va: 3};
        td  = '{ht: 20, hs: 3, hb: 3, ha: 10, vt: 8, vs: 1, vb: 1, va: 4};

        rstn = 1'b0; en = 1'b0; cfg_valid = 1'b0;
        drive_cfg(DEF);
        repeat (3) @(negedge clk);
        check("reset_ready", cfg_ready, 1);
        check("reset_hs_pol1", hs_out, 0);
        check("reset_hs_pol0", hs_out_n, 1);
        check("reset_vs_pol0", vs_out_n, 1);
        check("reset_de", de_out, 0);

        // Default 720p timing: line period, hsync width, first active pixel.
        rstn = 1'b1; en = 1'b1;
        @(negedge clk);
        check("en_frame_start", frame_start, 1);
        n = 0; hsc = 0;
        do begin
            hsc += int'(hs_out);
            n++;
            @(negedge clk);
        end while (!line_start && n < 3000);
        check("line_period", n, 1650);
        check("hs_width", hsc, 40);
        lc = 1; pos = 0; n = 0;
        do begin
            @(negedge clk);
            n++;
            if (line_start) begin lc++; pos = 0; end
            else pos++;
        end while (!de_out && n < 50000);
        check("de_line", lc, 25);
        check("de_hpos", pos, 260);
        check("first_x", int'(x_act), 0);
        check("first_y", int'(y_act), 0);
        n = 0;
        while (de_out && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check("de_len", n, 1280);

        for (int i = 0; i < 6; i++) begin
            en = vecs[i].en_v;
            @(negedge clk);
            drive_cfg(vecs[i].t);
            cfg_valid = 1'b1;
            check($sformatf("vec%0d_ready_before", i), cfg_ready, 1);
            @(negedge clk);
            cfg_valid = 1'b0;
            check($sformatf("vec%0d_err", i), cfg_err, int'(vecs[i].exp_err));
            check($sformatf("vec%0d_ready", i), cfg_ready, int'(vecs[i].exp_err));
            @(negedge clk);
            check($sformatf("vec%0d_err_clear", i), cfg_err, 0);
            check($sformatf("vec%0d_ready_after", i), cfg_ready, 1);
        end

        // Stop mid-line for 100 clocks, then restart.
        en = 1'b1;
        repeat (40) @(negedge clk);
        en = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (hs_out || vs_out || de_out || frame_start || line_start || x_act != 0 || y_act != 0 ||
                !hs_out_n || !vs_out_n) bad++;
        end
        check("en0_idle", bad, 0);
        en = 1'b1;
        @(negedge clk);
        check("restart_fs", frame_start, 1);

        // Mid-frame load: current frame finishes, then 10x6 frames.
        repeat (30) @(negedge clk);
        offer_once(ta);
        check("load_ready_low", cfg_ready, 0);
        wait_fs(200, n);
        check("load_fs_found", int'(frame_start), 1);
        check("load_ready_back", cfg_ready, 1);
        n = 0; li = -1; dec = 0; xsum = 0; mask = 0;
        do begin
            if (line_start) li++;
            if (de_out) begin
                dec++;
                xsum += int'(x_act);
                mask |= (1 << li);
            end
            n++;
            @(negedge clk);
        end while (!frame_start && n < 500);
        check("small_frame_len", n, 60);
        check("small_de_count", dec, 12);
        check("small_x_sum", xsum, 18);
        check("small_de_lines", mask, 28);

        // Back-to-back offers: second stalls until the first swaps in.
        offer_once(tb_);
        drive_cfg(tc);
        cfg_valid = 1'b1;
        st = 0; errs = 0;
        while (!cfg_ready && st < 300) begin
            errs += int'(cfg_err);
            st++;
            @(negedge clk);
        end
        check("stall_seen", int'(st > 0), 1);
        check("stall_no_err", errs, 0);
        check("stall_released", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        check("second_taken", cfg_ready, 0);
        wait_fs(300, n);
        check("b_frame_len", n, 72);
        wait_fs(300, n);
        check("c_frame_len", n, 84);

        // Reset mid-frame with a set pending.
        offer_once(td);
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("mid_reset_hs_pol0", hs_out_n, 1);
        check("mid_reset_vs_pol0", vs_out_n, 1);
        check("mid_reset_hs_pol1", hs_out, 0);
        check("mid_reset_ready", cfg_ready, 1);
        check("mid_reset_fs", frame_start, 0);
        @(negedge clk);
        rstn = 1'b1;
        wait_fs(5, n);
        check("post_reset_fs", n, 1);
        hsc = 0; vsl = 0; dec = 0;
        for (int i = 0; i < 1650; i++) begin
            hsc += int'(!hs_out_n);
            vsl += int'(!vs_out_n);
            dec += int'(de_out_n);
            @(negedge clk);
        end
        check("post_reset_hs_low", hsc, 40);
        check("post_reset_vs_low", vsl, 1650);
        check("post_reset_no_de", dec, 0);
        check("post_reset_line", line_start, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1500000;
        n_bad++;
        $display("FAIL watchdog: actual timeout required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sync_vg_prog.md
SYNC_VG_PROG -- requirements
Module: sync_vg_prog

Interface
REQ-001 Parameters SHALL be:
  - X_BITS, default 12: width of horizontal fields.
  - Y_BITS, default 12: width of vertical fields.
  - HS_POL, default 1: hs_out active level.
  - VS_POL, default 1: vs_out active level.
  - H_TOTAL/H_SYNC/H_BP/H_ACT, default 1650/40/220/1280: power-up horizontal timing.
  - V_TOTAL/V_SYNC/V_BP/V_ACT, default 750/5/20/720: power-up vertical timing.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  - clk, in, 1: pixel clock; one clock domain only.
  - rstn, in, 1: synchronous, active-low reset.
  - en, in, 1: timing run enable.
  - cfg_valid, in, 1: a new timing set is offered.
  - cfg_ready, out, 1: a timing set can be accepted.
  - cfg_h_total, cfg_h_sync, cfg_h_bp, cfg_h_act, in, X_BITS each: offered horizontal timing.
  - cfg_v_total, cfg_v_sync, cfg_v_bp, cfg_v_act, in, Y_BITS each: offered vertical timing.
  - cfg_err, out, 1: one-cycle pulse when an offered set is rejected.
  - hs_out, vs_out, de_out, out, 1 each: horizontal sync, vertical sync, data enable.
  - frame_start, out, 1: one-cycle pulse on the first pixel of a frame.
  - line_start, out, 1: one-cycle pulse on the first pixel of a line.
  - x_act, out, X_BITS: active-area column.
  - y_act, out, Y_BITS: active-area row.

Function
REQ-003 The h counter SHALL count 0..h_total-1 and then wrap to 0; the v counter SHALL advance on the h wrap and wrap to 0 after v_total-1. Both use the active timing set.
REQ-004 All outputs SHALL be registered and reflect the counter values of the previous cycle (1-cycle latency).
REQ-005 hs_out SHALL equal HS_POL when h<h_sync and ~HS_POL otherwise; vs_out SHALL follow the same rule with v, v_sync and VS_POL.
REQ-006 de_out SHALL be 1 only when both of these hold:
  - h_sync+h_bp <= h <= h_sync+h_bp+h_act-1
  - v_sync+v_bp <= v <= v_sync+v_bp+v_act-1
REQ-007 x_act SHALL be h-(h_sync+h_bp) when h>=h_sync+h_bp, else 0. y_act SHALL follow the same rule with v, v_sync and v_bp. Both are truncated to X_BITS/Y_BITS.
REQ-008 frame_start SHALL be 1 when h==0 and v==0. line_start SHALL be 1 when h==0.
REQ-009 A config transfer SHALL occur on a cycle with cfg_valid and cfg_ready both 1; the cfg_* values are captured into a pending register and cfg_ready drops on the following cycle.
REQ-010 The pending set SHALL become active on the cycle where h==h_total-1 and v==v_total-1, so the next frame uses the new timing. cfg_ready returns to 1 on the following cycle.
REQ-011 An offered set SHALL be rejected (no capture, cfg_err=1 for one cycle, cfg_ready stays 1) if any of these hold:
  - any field is 0
  - h_sync+h_bp+h_act > h_total
  - v_sync+v_bp+v_act > v_total
  - Sums are evaluated one bit wider than the field width.
REQ-012 While en=0, both counters SHALL hold at 0 and the outputs SHALL stay inactive: hs/vs at their inactive level, de=0, pulses=0, x_act=y_act=0. While en=0, a pending set SHALL be applied immediately.
REQ-013 On the en 0->1 edge, the counters SHALL start at h=0, v=0, and frame_start SHALL follow one cycle later.
REQ-014 If cfg_valid arrives while a set is pending, it SHALL be stalled (cfg_ready=0) with no loss and no error.
REQ-015 A config change SHALL never shorten or truncate the frame currently in progress.

Reset
REQ-016 On rstn=0 at a clk edge, the block SHALL take these values:
  - Counters: 0.
  - Active timing set: parameter defaults.
  - Pending set: discarded.
  - hs_out=~HS_POL, vs_out=~VS_POL.
  - de_out, frame_start, line_start, cfg_err: 0.
  - x_act, y_act: 0.
  - cfg_ready: 1.
REQ-017 Reset asserted mid-frame or mid-handshake SHALL take effect on that edge with no residual pulse afterwards.

Structure
REQ-018 Standard timing constants (720p60, 1080p60, 480p60) SHALL reside in the shared package sync_vg_pkg.
REQ-019 One sub-module, sync_vg_axis, SHALL be used. It holds a counter, its wrap and the sync/active decode, and is instantiated once for h and once for v.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
  - Defaults, en=1 -> line period 1650 clk, hs active for 40 clk, de high for 1280 clk per line and 720 lines, first x_act=0 at h=260.
  - Load h 10/2/2/4, v 6/1/1/3 mid-frame -> old frame completes, then 60 clk/frame, de for 4 clk on v=2..4, x_act 0..3.
  - Offer h_act=7 with h_total=10, h_sync=2, h_bp=2 -> cfg_err for 1 clk, timing unchanged, cfg_ready=1.
  - Back-to-back cfg_valid -> second offer held with cfg_ready=0 until the first applies, then accepted.
  - en=0 for 100 clk mid-line -> outputs inactive; after en=1, frame_start one cycle later.
  - HS_POL=0, VS_POL=0, rstn pulsed mid-frame -> hs_out=vs_out=1 in reset, low pulses after, no stray de.
